// File: rtl/snn_addr_sequencer_pkg.sv
// Shared types for the SNN weight-read address sequencer.
// Holds the FSM state encoding and a constant-width helper.
package snn_addr_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snn_addr_sequencer.sv
// Sweeps all output neurons per input spike, issuing weight reads and
// driving the external neuron-state address counter in lockstep.
module snn_addr_sequencer
    import snn_addr_sequencer_pkg::*;
#(
    parameter int N_IN  = 64,
    parameter int N_OUT = 128,
    localparam int IW = clog2(N_IN),
    localparam int OW = clog2(N_OUT),
    localparam int AW = IW + OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spk_valid,
    input  logic [IW-1:0] spk_idx,
    output logic          spk_ready,
    input  logic          eot_valid,
    output logic          eot_ready,
    input  logic          hold,
    output logic          w_rd_en,
    output logic [AW-1:0] w_addr,
    output logic          cnt_clr,
    output logic          cnt_inc,
    output logic          upd_valid,
    output logic          upd_last,
    output logic          ts_done,
    output logic          busy
);

    localparam logic [OW-1:0] J_LAST = OW'(N_OUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_q;
    logic [OW-1:0] j_q;

    always_comb begin
        state_d   = state_q;
        spk_ready = 1'b0;
        eot_ready = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        w_rd_en   = 1'b0;
        ts_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                spk_ready = 1'b1;
                eot_ready = ~spk_valid;
                if (spk_valid) begin
                    cnt_clr = 1'b1;
                    state_d = RUN;
                end else if (eot_valid) begin
                    state_d = DONE;
                end
            end
            RUN: begin
                if (!hold) begin
                    w_rd_en = 1'b1;
                    cnt_inc = 1'b1;
                    if (j_q == J_LAST) state_d = IDLE;
                end
            end
            DONE: begin
                ts_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes trail the read by one cycle to line up with RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            j_q       <= '0;
            upd_valid <= 1'b0;
            upd_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            upd_valid <= w_rd_en;
            upd_last  <= w_rd_en && (j_q == J_LAST);
            if (spk_valid && spk_ready) begin
                idx_q <= spk_idx;
                j_q   <= '0;
            end else if (w_rd_en) begin
                j_q <= j_q + OW'(1);
            end
        end
    end

    assign w_addr = {idx_q, j_q};
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_snn_addr_sequencer.sv
// Scoreboard bench for snn_addr_sequencer with N_IN=4, N_OUT=8.
module tb_snn_addr_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 8;
    localparam int IW = 2;
    localparam int OW = 3;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          spk_valid;
    logic [IW-1:0] spk_idx;
    logic          spk_ready;
    logic          eot_valid;
    logic          eot_ready;
    logic          hold;
    logic          w_rd_en;
    logic [AW-1:0] w_addr;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          upd_valid;
    logic          upd_last;
    logic          ts_done;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [AW-1:0] exp_q[$];
    logic [OW-1:0] cnt;

    snn_addr_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst),
        .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_ready(spk_ready),
        .eot_valid(eot_valid), .eot_ready(eot_ready),
        .hold(hold),
        .w_rd_en(w_rd_en), .w_addr(w_addr),
        .cnt_clr(cnt_clr), .cnt_inc(cnt_inc),
        .upd_valid(upd_valid), .upd_last(upd_last),
        .ts_done(ts_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External address counter model.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_inc) cnt <= cnt + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && w_rd_en) begin
            if (exp_q.size() == 0) chk("rd_extra", 1, 0);
            else chk("w_addr", 32'(w_addr), 32'(exp_q.pop_front()));
            chk("cnt_lockstep", 32'(cnt), 32'(w_addr[OW-1:0]));
        end
    end

    task automatic wait_spk(output int acc);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (spk_ready) begin
                chk("cnt_clr", cnt_clr, 1);
                acc = cyc;
                for (int j = 0; j < N_OUT; j++)
                    exp_q.push_back({spk_idx, OW'(j)});
                return;
            end
        end
        chk("spk_timeout", 0, 1);
    endtask

    task automatic send_spike(input logic [IW-1:0] idx, output int acc);
        @(posedge clk); #1;
        spk_valid = 1'b1;
        spk_idx   = idx;
        wait_spk(acc);
        @(posedge clk); #1;
        spk_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, a2, nup, eacc, lastc, tsc, nts;
        rst = 1'b1; spk_valid = 1'b0; spk_idx = '0;
        eot_valid = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_spk_ready", spk_ready, 1);
        chk("rst_eot_ready", eot_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", w_rd_en, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_last", upd_last, 0);
        chk("rst_ts_done", ts_done, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_cnt_inc", cnt_inc, 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        spk_valid = 1'b1; #1;
        chk("rst_eot_blocked", eot_ready, 0);
        spk_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single spike, timing of every strobe.
        send_spike(2'd3, a);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("t1_rd_en", w_rd_en, (k <= 8) ? 1 : 0);
            chk("t1_upd_valid", upd_valid, (k >= 2 && k <= 9) ? 1 : 0);
            chk("t1_upd_last", upd_last, (k == 9) ? 1 : 0);
            chk("t1_spk_ready", spk_ready, (k >= 9) ? 1 : 0);
            chk("t1_busy", busy, (k <= 8) ? 1 : 0);
        end

        // Hold for 3 cycles at j = 4.
        send_spike(2'd3, a);
        nup = 0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            hold = (k >= 5 && k <= 7);
            @(negedge clk);
            if (upd_valid) nup++;
            if (k >= 5 && k <= 7) begin
                chk("hold_rd_en", w_rd_en, 0);
                chk("hold_addr", 32'(w_addr), 28);
            end
            if (k == 12) chk("hold_upd_last", upd_last, 1);
        end
        hold = 1'b0;
        chk("hold_upd_count", nup, 8);

        // Back-to-back spikes 1 then 2.
        @(posedge clk); #1;
        spk_valid = 1'b1; spk_idx = 2'd1;
        wait_spk(a);
        @(posedge clk); #1;
        spk_idx = 2'd2;
        wait_spk(a2);
        @(posedge clk); #1;
        spk_valid = 1'b0;
        chk("b2b_gap", a2 - a, 9);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_drained", exp_q.size(), 0);

        // Spike and EOT together.
        spk_valid = 1'b1; spk_idx = 2'd0; eot_valid = 1'b1;
        wait_spk(a);
        chk("both_eot_blocked", eot_ready, 0);
        @(posedge clk); #1;
        spk_valid = 1'b0;
        eacc = -1; lastc = -1; tsc = -1; nts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_last) lastc = cyc;
            if (ts_done) begin nts++; tsc = cyc; end
            if (eot_valid && eot_ready) begin
                eacc = cyc;
                @(posedge clk); #1;
                eot_valid = 1'b0;
            end
        end
        eot_valid = 1'b0;
        chk("both_eot_acc", eacc - a, 9);
        chk("both_last", lastc - a, 9);
        chk("both_ts_cyc", tsc - a, 10);
        chk("both_ts_count", nts, 1);

        // EOT only.
        @(posedge clk); #1;
        eot_valid = 1'b1;
        @(negedge clk);
        chk("eot_ready", eot_ready, 1);
        chk("eot_busy0", busy, 0);
        @(posedge clk); #1;
        eot_valid = 1'b0;
        @(negedge clk);
        chk("eot_ts_done", ts_done, 1);
        chk("eot_busy1", busy, 1);
        @(negedge clk);
        chk("eot_ts_clear", ts_done, 0);
        chk("eot_busy2", busy, 0);

        // Asynchronous reset mid-sweep at j = 5.
        send_spike(2'd2, a);
        for (int k = 2; k <= 6; k++) begin @(posedge clk); #1; end
        chk("ar_pre_upd", upd_valid, 1);
        chk("ar_pre_addr", 32'(w_addr), 21);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("ar_busy", busy, 0);
        chk("ar_rd_en", w_rd_en, 0);
        chk("ar_upd_valid", upd_valid, 0);
        chk("ar_w_addr", 32'(w_addr), 0);
        chk("ar_spk_ready", spk_ready, 1);
        @(negedge clk);
        chk("ar_upd_hold", upd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ar_upd_after", upd_valid, 0);
        send_spike(2'd1, a);
        @(negedge clk);
        chk("ar_restart_addr", 32'(w_addr), 8);
        chk("ar_restart_rd", w_rd_en, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_addr_sequencer.md
# snn_addr_sequencer

Control stage directly upstream of the neuron-state address counter. It accepts input-spike indices and end-of-timestep markers over valid/ready. For each spike it sweeps every output neuron: it issues synaptic-weight reads and drives the counter's `clr`/`inc` so that counter address equals the neuron index being updated. It emits a read-latency-aligned update strobe for the neuron datapath and a `ts_done` pulse once a timestep has fully drained.

## Interface
- `N_IN`, 64, number of input neurons; any value ≥2.
- `N_OUT`, 128, number of output neurons; power of two, ≥2.
- Derived localparams: IW = clog2(N_IN), OW = clog2(N_OUT), AW = IW+OW.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spk_valid`  in  1  spike index offered.
- `spk_idx`  in  IW  input-neuron index; values ≥ N_IN are undefined usage.
- `spk_ready`  out  1  spike accepted when `spk_valid & spk_ready`.
- `eot_valid`  in  1  end-of-timestep marker offered.
- `eot_ready`  out  1  marker accepted when `eot_valid & eot_ready`.
- `hold`  in  1  downstream stall; freezes the sweep.
- `w_rd_en`  out  1  weight-memory read enable (synchronous RAM, 1-cycle latency).
- `w_addr`  out  AW  weight address = {idx, j}.
- `cnt_clr`  out  1  to the address counter's `clr`.
- `cnt_inc`  out  1  to the address counter's `inc`.
- `upd_valid`  out  1  weight data valid on RAM output this cycle.
- `upd_last`  out  1  qualifies `upd_valid` for j = N_OUT-1.
- `ts_done`  out  1  one-cycle pulse: timestep complete.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE. Registers: `idx_q` (IW bits), `j_q` (OW bits), and the pipeline flags `upd_valid` and `upd_last`.
- IDLE: `spk_ready = 1`, `eot_ready = ~spk_valid`. Spikes have priority over EOT.
- Spike accept: `idx_q <= spk_idx`, `j_q <= 0`, state goes to RUN. `cnt_clr = 1` in the accept cycle. `cnt_clr` is combinational on the handshake.
- RUN with `hold = 0`: `w_rd_en = 1` and `cnt_inc = 1`. `j_q` increments. When `j_q == N_OUT-1`, go to IDLE and `j_q` wraps to 0.
- RUN with `hold = 1`: `w_rd_en = 0`, `cnt_inc = 0`, `j_q` and state frozen.
- `w_addr` = {`idx_q`, `j_q`} at all times; it is only meaningful while `w_rd_en` is high.
- EOT accept in IDLE goes to DONE. DONE lasts exactly one cycle with `ts_done = 1`, then returns to IDLE. Both ready outputs are 0 in DONE and RUN.
- `upd_valid <= w_rd_en`; `upd_last <= w_rd_en & (j_q == N_OUT-1)`. These flags update every cycle regardless of `hold`.
- The counter address equals `j_q` in every RUN cycle. This holds because `clr` lands at RUN entry and `inc` is applied in lockstep with `j_q`.

## Timing
- Reset (asynchronous): state IDLE, `idx_q = 0`, `j_q = 0`, `upd_valid = 0`, `upd_last = 0`. All combinational outputs follow: `spk_ready = 1`, `eot_ready = ~spk_valid`, all others 0.
- Accept at cycle t gives the first read at t+1 and the first `upd_valid` at t+2.
- Without hold, the last read is at t+N_OUT and `upd_last` is at t+N_OUT+1. `spk_ready` is high again at t+N_OUT+1, so back-to-back spikes run at one spike per N_OUT+1 cycles.
- EOT is accepted no earlier than the cycle carrying the final `upd_valid`. `ts_done` therefore always follows the last update of the timestep by at least 1 cycle.
- Simultaneous `spk_valid` and `eot_valid` in IDLE: the spike wins and the EOT waits.
- EOT with no spikes in the timestep: `ts_done` one cycle after accept.
- Reset mid-RUN: the sweep is abandoned and no `upd_valid` is produced after reset. The counter is re-cleared on the next accept.

## Structure
- Shared package: the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the clog2 function.
- The block has no sub-module: one FSM plus its registers. The address counter is instantiated alongside it at the next level up, not inside.

## Test plan
- Reset, then one spike with `spk_idx = 3` (N_IN = 4, N_OUT = 8): `w_addr` steps 24..31 on cycles t+1..t+8; `upd_valid` is high t+2..t+9; `upd_last` fires at t+9; the counter model reads 0..7 in lockstep.
- `hold` high for 3 cycles at j = 4: `w_addr` stays 28 with `w_rd_en = 0`. The sweep resumes and ends 3 cycles later. There are exactly 8 `upd_valid` pulses.
- Two back-to-back spikes (1, 2): the second is accepted at t+9. The `w_addr` streams are 8..15 then 16..23 with no lost or duplicated reads.
- `spk_valid` and `eot_valid` raised together in IDLE: spike accepted and `eot_ready = 0` until the sweep ends. `ts_done` pulses once, after the final `upd_last`.
- EOT only: `eot_ready = 1` and `ts_done` at the next cycle. `busy` is high for 1 cycle.
- Asynchronous `rst` asserted at j = 5: outputs drop to reset values without waiting for a clock edge. A following spike restarts at j = 0 with `cnt_clr` high.
